// File: rtl/mem_model_pkg.sv
// Shared definitions for the parametrised burst memory model.
// Holds the access FSM state type, the derived geometry for the default
// configuration (4 x 64-bit beats per 256-bit line, 512 B pages, 4096 lines),
// and the latency clamp used so that a zero or negative latency never
// produces a wait of less than one cycle.
package mem_model_pkg;

  typedef enum logic [2:0] {IDLE, GRANT, WAIT, BURST, DONE} state_t;

  // Geometry of the default parameter set; instances derive their own copies
  // from their actual parameters.
  localparam int BEATS      = 4;
  localparam int BEAT_IDX_W = 2;
  localparam int LINE_OFF_W = 5;
  localparam int PAGE_OFF_W = 9;
  localparam int LINE_IDX_W = 12;

  function automatic int clamp_lat(input int cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   req        request vector, one bit per requester
//   en         accept the current winner and advance the pointer
//   grant      one-hot winner (all zero when nothing requests)
//   grant_idx  binary index of the winner
// The pointer names the highest-priority requester; it resets to 0 and
// moves to the port after the winner whenever a grant is accepted.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0]                       req,
  input  logic                               en,
  output logic [N-1:0]                       grant,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] grant_idx
);

  localparam int idx_w = (N > 1) ? $clog2(N) : 1;

  logic [idx_w-1:0] ptr_q;
  logic [idx_w-1:0] cand;

  // Scan from the farthest offset back to the pointer so the closest
  // requester (in round-robin order) is the one left standing.
  always_comb begin
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int off = N - 1; off >= 0; off--) begin
      cand = idx_w'((int'(ptr_q) + off) % N);
      if (req[cand]) grant_idx = cand;
    end
    grant = '0;
    if (|req) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (en && |req) begin
      ptr_q <= (grant_idx == idx_w'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/param_burst_mem_multiport.sv
// Cycle-accurate burst memory responder shared by several line-burst
// requesters, with round-robin arbitration and an open-page latency model.
// Ports:
//   clk, rst    clock and asynchronous active-low reset
//   read_i      per-port read request (level, held until resp_o)
//   write_i     per-port write request (level, held until resp_o)
//   addr_i      per-port byte address; offset-within-line bits ignored
//   wdata_i     per-port write beat, consumed when wbeat_o is high
//   rdata_o     shared read beat bus
//   rbeat_o     rdata_o carries a valid beat for this port
//   wbeat_o     the port's wdata_i is written this cycle
//   resp_o      one-cycle completion pulse
//   page_hit_o  grant-cycle indication that the access hit the open page
module param_burst_mem_multiport
  import mem_model_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_BITS   = 256,
  parameter int BEAT_BITS   = 64,
  parameter int MISS_CYCLES = 50,
  parameter int HIT_CYCLES  = 25,
  parameter int PAGE_BYTES  = 512,
  parameter int MEM_LINES   = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 read_i,
  input  logic [NUM_PORTS-1:0]                 write_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0][BEAT_BITS-1:0]  wdata_i,
  output logic [BEAT_BITS-1:0]                 rdata_o,
  output logic [NUM_PORTS-1:0]                 rbeat_o,
  output logic [NUM_PORTS-1:0]                 wbeat_o,
  output logic [NUM_PORTS-1:0]                 resp_o,
  output logic                                 page_hit_o
);

  localparam int n_beats    = LINE_BITS / BEAT_BITS;
  localparam int beat_idx_w = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam int line_off_w = $clog2(LINE_BITS / 8);
  localparam int page_off_w = $clog2(PAGE_BYTES);
  localparam int line_idx_w = $clog2(MEM_LINES);
  localparam int page_w     = ADDR_WIDTH - page_off_w;
  localparam int port_w     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int miss_lat   = clamp_lat(MISS_CYCLES);
  localparam int hit_lat    = clamp_lat(HIT_CYCLES);
  localparam int mem_depth  = MEM_LINES << beat_idx_w;

  state_t                  state_q;
  logic [port_w-1:0]       port_q;
  logic [line_idx_w-1:0]   line_q;
  logic                    wr_q;
  logic [31:0]             cnt_q;
  logic [beat_idx_w-1:0]   beat_q;
  logic                    page_valid_q;
  logic [page_w-1:0]       page_q;

  logic [NUM_PORTS-1:0]    req;
  logic [NUM_PORTS-1:0]    grant;
  logic [port_w-1:0]       grant_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    hit;
  logic [31:0]             lat_sel;
  logic [line_idx_w+beat_idx_w-1:0] mem_idx;
  logic                    unused_addr;

  // One entry per beat, so a beat write touches a single word.
  logic [BEAT_BITS-1:0]    mem [mem_depth];

  assign req         = read_i | write_i;
  assign sel_addr    = addr_i[port_q];
  assign hit         = page_valid_q && (sel_addr[ADDR_WIDTH-1:page_off_w] == page_q);
  assign lat_sel     = hit ? 32'(hit_lat) : 32'(miss_lat);
  assign mem_idx     = {line_q, beat_q};
  assign unused_addr = ^addr_i;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en        (state_q == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Access sequencer. The counter is loaded with LAT-1 at GRANT and the
  // FSM leaves WAIT when it reads 1, so the first beat lands exactly LAT
  // cycles after GRANT; a latency of 1 skips WAIT altogether.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      port_q       <= '0;
      line_q       <= '0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      beat_q       <= '0;
      page_valid_q <= 1'b0;
      page_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            port_q  <= grant_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          line_q       <= sel_addr[line_off_w +: line_idx_w];
          // A port raising both requests is served as a read.
          wr_q         <= write_i[port_q] & ~read_i[port_q];
          page_q       <= sel_addr[ADDR_WIDTH-1:page_off_w];
          page_valid_q <= 1'b1;
          beat_q       <= '0;
          cnt_q        <= lat_sel - 32'd1;
          state_q      <= (lat_sel == 32'd1) ? BURST : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 32'd1;
          if (cnt_q == 32'd1) state_q <= BURST;
        end
        BURST: begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == beat_idx_w'(n_beats - 1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Backing array is deliberately left out of reset; an aborted write keeps
  // whatever beats already landed.
  always_ff @(posedge clk) begin
    if (state_q == BURST && wr_q) mem[mem_idx] <= wdata_i[port_q];
  end

  // Handshake outputs decode directly from state, so an asynchronous reset
  // clears them in the same instant.
  always_comb begin
    rbeat_o = '0;
    wbeat_o = '0;
    resp_o  = '0;
    rdata_o = '0;
    if (state_q == BURST) begin
      if (wr_q) begin
        wbeat_o[port_q] = 1'b1;
      end else begin
        rbeat_o[port_q] = 1'b1;
        rdata_o         = mem[mem_idx];
      end
    end
    if (state_q == DONE) resp_o[port_q] = 1'b1;
    page_hit_o = (state_q == GRANT) && hit;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_chk
    a_no_rw_collision: assert property (@(posedge clk) disable iff (!rst)
      !(read_i[g] && write_i[g]));
  end

  a_request_held: assert property (@(posedge clk) disable iff (!rst)
    ((state_q == GRANT) || (state_q == WAIT) || (state_q == BURST))
      |-> (read_i[port_q] || write_i[port_q]));

endmodule
